seq_alu_engine: RTL

Parametrised sequence-generator engine: a control FSM driving a two-register ALU datapath that emits one sequence term per clock (Fibonacci, arithmetic, countdown or doubling) with CR16-style status flags. It is the generalised successor of the fixed 16-bit Fibonacci FSM/ALU pair. It adds configurable width and term count, mode select, a start/busy/done handshake, per-term valid strobes and optional stop-on-carry. It sits beside the register file/ALU as a self-test and demo pattern source, for example for Pong paddle/ball step sequences.

---
 rtl/seq_alu_pkg.sv | 22 ++
 rtl/seq_alu_engine_alu.sv | 26 ++
 rtl/seq_alu_engine.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared encodings for the sequence-generator engine
package seq_alu_pkg;
    typedef enum logic [1:0] {
        MODE_FIB   = 2'd0,
        MODE_ARITH = 2'd1,
        MODE_CDOWN = 2'd2,
        MODE_DBL   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;
endpackage

// File: rtl/seq_alu_engine_alu.sv
// seq_alu: combinational add/sub with {C,L,F,Z,N} status flags
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        flags = '0;
        // the extra bit is carry-out on add and borrow (a<b) on subtract
        flags[FLG_C] = sum[WIDTH];
        flags[FLG_L] = sub & sum[WIDTH];
        flags[FLG_F] = (sub ? a[WIDTH-1] != b[WIDTH-1] : a[WIDTH-1] == b[WIDTH-1])
                       && (result[WIDTH-1] != a[WIDTH-1]);
        flags[FLG_Z] = result == '0;
        flags[FLG_N] = result[WIDTH-1];
    end
endmodule

// File: rtl/seq_alu_engine.sv
// seq_alu_engine: FSM-driven two-register datapath emitting one sequence term per clock
module seq_alu_engine
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [CNT_W-1:0] count,
    input  logic             stop_on_carry,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             term_valid,
    output logic [WIDTH-1:0] term_out,
    output logic [CNT_W-1:0] term_idx,
    output logic [4:0]       flag_reg
);
    state_t state, state_n;
    mode_t md;
    logic [WIDTH-1:0] a, b, sa, sb, res;
    logic [CNT_W-1:0] k, cnt;
    logic soc, last, cstop;
    logic [4:0] flags;

    seq_alu #(.WIDTH(WIDTH)) alu (
        .a(a),
        .b(md == MODE_DBL ? a : b),
        .sub(md == MODE_CDOWN),
        .result(res),
        .flags(flags)
    );

    assign last = k == cnt - 1'b1;
    assign cstop = soc & flags[FLG_C];

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = start ? S_LOAD : S_IDLE;
            S_LOAD: state_n = cnt == '0 ? S_DONE : S_STEP;
            S_STEP: state_n = (last || cstop) ? S_DONE : S_STEP;
            default: state_n = S_IDLE;
        endcase
    end

    // outputs are registered, so they trail the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            md <= MODE_FIB;
            a <= '0;
            b <= '0;
            sa <= '0;
            sb <= '0;
            k <= '0;
            cnt <= '0;
            soc <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            term_valid <= 1'b0;
            term_out <= '0;
            term_idx <= '0;
            flag_reg <= '0;
        end else begin
            state <= state_n;
            busy <= state == S_LOAD || state == S_STEP;
            done <= state == S_DONE;
            term_valid <= state == S_STEP;
            if (state == S_IDLE && start) begin
                md <= mode_t'(mode);
                sa <= seed_a;
                sb <= seed_b;
                cnt <= count;
                soc <= stop_on_carry;
                err <= 1'b0;
            end
            if (state == S_LOAD) begin
                a <= sa;
                b <= sb;
                k <= '0;
            end
            if (state == S_STEP) begin
                term_out <= a;
                term_idx <= k;
                flag_reg <= flags;
                a <= md == MODE_FIB ? b : res;
                b <= md == MODE_FIB ? res : b;
                k <= k + 1'b1;
                if (!last && cstop) err <= 1'b1;
            end
        end
    end
endmodule
